mp_regfile_sb: RTL and testbench

// - Parametrised multi-port register file for the superscalar issue stage.
//   NUM_RD combinational read ports and NUM_WR write ports with same-cycle write->read bypass.
// - Adds a per-register pending scoreboard (set on allocate, cleared on writeback) and a

---
 rtl/mp_regfile_pkg.sv | 33 +++
 rtl/mp_regfile_sb_if.sv | 34 +++
 rtl/rf_bypass_sel.sv | 39 +++
 rtl/mp_regfile_sb.sv | 143 ++++++++++++++
 tb/tb_mp_regfile_sb.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_regfile_pkg.sv
// Shared types and helpers for the multi-port register file with pending scoreboard.
// The write-port priority function is used by every read port's bypass selector.
package mp_regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

  localparam int unsigned RF_ZERO_REG = 0;
  localparam int unsigned RF_MAX_WR   = 32;
  localparam int unsigned RF_PORT_W   = 5;

  typedef struct packed {
    logic                 hit;
    logic [RF_PORT_W-1:0] port;
  } rf_wr_sel_t;

  // Later ports overwrite earlier ones, so the highest matching index is returned.
  function automatic rf_wr_sel_t rf_last_hit(input logic [RF_MAX_WR-1:0] wr_en,
                                             input logic [RF_MAX_WR-1:0] addr_eq);
    rf_wr_sel_t sel;
    sel = '0;
    for (int unsigned j = 0; j < RF_MAX_WR; j++) begin
      if (wr_en[j] && addr_eq[j]) begin
        sel.hit  = 1'b1;
        sel.port = RF_PORT_W'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mp_regfile_sb_if.sv
// Issue/writeback bus of the register file: read, write, allocate and flush-sweep signals.
// The master side is rename/issue/writeback; the slave side is the register file itself.
interface mp_regfile_sb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int NUM_RD         = 8,
  parameter int NUM_WR         = 4,
  parameter int NUM_ALLOC      = 4
);

  logic [NUM_RD*REG_ADDR_WIDTH-1:0]    i_Read_Addr;
  logic [NUM_RD*DATA_WIDTH-1:0]        o_Read_Data;
  logic [NUM_RD-1:0]                   o_Read_Ready;
  logic [NUM_WR-1:0]                   i_Write_Enable;
  logic [NUM_WR*REG_ADDR_WIDTH-1:0]    i_Write_Addr;
  logic [NUM_WR*DATA_WIDTH-1:0]        i_Write_Data;
  logic [NUM_ALLOC-1:0]                i_Alloc_Enable;
  logic [NUM_ALLOC*REG_ADDR_WIDTH-1:0] i_Alloc_Addr;
  logic                                i_Clear_Req;
  logic                                o_Clear_Busy;

  modport master (
    output i_Read_Addr, i_Write_Enable, i_Write_Addr, i_Write_Data,
           i_Alloc_Enable, i_Alloc_Addr, i_Clear_Req,
    input  o_Read_Data, o_Read_Ready, o_Clear_Busy
  );

  modport slave (
    input  i_Read_Addr, i_Write_Enable, i_Write_Addr, i_Write_Data,
           i_Alloc_Enable, i_Alloc_Addr, i_Clear_Req,
    output o_Read_Data, o_Read_Ready, o_Clear_Busy
  );

endinterface

// File: rtl/rf_bypass_sel.sv
// Per-read-port write->read bypass: finds the highest enabled write port whose
// address matches this read address and forwards its data.
module rf_bypass_sel
  import mp_regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int NUM_WR         = 4
) (
  input  logic [REG_ADDR_WIDTH-1:0]        rd_addr_i,
  input  logic [NUM_WR-1:0]                wr_en_i,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]     wr_data_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             hit_o
);

  logic [RF_MAX_WR-1:0] wr_en;
  logic [RF_MAX_WR-1:0] addr_eq;
  rf_wr_sel_t           sel;

  always_comb begin
    wr_en   = '0;
    addr_eq = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_en[j]   = wr_en_i[j];
      addr_eq[j] = (wr_addr_i[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rd_addr_i);
    end
    sel    = rf_last_hit(wr_en, addr_eq);
    hit_o  = sel.hit;
    data_o = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (sel.hit && (sel.port == RF_PORT_W'(j))) begin
        data_o = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/mp_regfile_sb.sv
// Multi-port register file for the issue stage with same-cycle bypass, a per-register
// pending scoreboard, and a one-register-per-cycle clear sweep used on pipeline flush.
module mp_regfile_sb
  import mp_regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int NUM_RD         = 8,
  parameter int NUM_WR         = 4,
  parameter int NUM_ALLOC      = 4
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  mp_regfile_sb_if.slave rf
);

  localparam int                  NREG     = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(RF_ZERO_REG);
  localparam logic [REG_ADDR_WIDTH-1:0] ONE_IDX  = REG_ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0]     rf_q [NREG];
  logic [NREG-1:0]           pend_q, pend_d;
  rf_state_e                 state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      sweep;

  assign sweep           = (state_q == RF_SWEEP);
  assign rf.o_Clear_Busy = sweep;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // The counter wraps to 0 on the last sweep index, leaving it clean for the next flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (rf.i_Clear_Req) begin
          state_d = RF_SWEEP;
          cnt_d   = ONE_IDX;
        end
      end
      RF_SWEEP: begin
        cnt_d = cnt_q + ONE_IDX;
        if (cnt_q == '1) begin
          state_d = RF_IDLE;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // Writebacks clear pending first so an allocate to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (sweep) begin
      pend_d[cnt_q] = 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (rf.i_Write_Enable[j] &&
            (rf.i_Write_Addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != ZERO_IDX)) begin
          pend_d[rf.i_Write_Addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = 1'b0;
        end
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        if (rf.i_Alloc_Enable[a] &&
            (rf.i_Alloc_Addr[a*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != ZERO_IDX)) begin
          pend_d[rf.i_Alloc_Addr[a*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (sweep) begin
      rf_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (rf.i_Write_Enable[j] &&
            (rf.i_Write_Addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != ZERO_IDX)) begin
          rf_q[rf.i_Write_Addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] <=
            rf.i_Write_Data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0]     byp_data;
    logic                      byp_hit;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_rdy;

    assign ra = rf.i_Read_Addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

    rf_bypass_sel #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .NUM_WR        (NUM_WR)
    ) u_byp (
      .rd_addr_i(ra),
      .wr_en_i  (rf.i_Write_Enable),
      .wr_addr_i(rf.i_Write_Addr),
      .wr_data_i(rf.i_Write_Data),
      .data_o   (byp_data),
      .hit_o    (byp_hit)
    );

    // While sweeping no operand may issue, and stored values are shown unbypassed.
    always_comb begin
      rd_data = rf_q[ra];
      rd_rdy  = ~pend_q[ra];
      if (sweep) begin
        rd_rdy = 1'b0;
      end else if (ra == ZERO_IDX) begin
        rd_data = '0;
        rd_rdy  = 1'b1;
      end else if (byp_hit) begin
        rd_data = byp_data;
        rd_rdy  = 1'b1;
      end
    end

    assign rf.o_Read_Data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    assign rf.o_Read_Ready[k]                        = rd_rdy;
  end

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Randomized bench for mp_regfile_sb against an array-based reference model of the
// register file, scoreboard and flush sweep, plus directed boundary scenarios.
module tb_mp_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int NR = 8;
  localparam int NW = 4;
  localparam int NA = 4;
  localparam int NREG = 128;

  logic clk;
  logic rst_n;

  mp_regfile_sb_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                     .NUM_ALLOC(NA)) bus ();

  mp_regfile_sb #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                  .NUM_ALLOC(NA)) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .rf     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // stimulus arrays
  int unsigned rd_a [NR];
  bit          wen  [NW];
  int unsigned wa   [NW];
  logic [31:0] wd   [NW];
  bit          aen  [NA];
  int unsigned aa   [NA];
  bit          clr;

  // reference model
  logic [31:0] m_reg  [NREG];
  bit          m_pend [NREG];
  int          m_pos;          // 0 = idle, otherwise index cleared this cycle
  logic        last_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_pos = 0;
  endtask

  function automatic logic [32:0] mdl_read(input int unsigned a);
    logic [32:0] r;
    if (m_pos != 0) return {1'b0, m_reg[a]};
    if (a == 0) return {1'b1, 32'h0};
    r = {~m_pend[a], m_reg[a]};
    for (int j = 0; j < NW; j++) begin
      if (wen[j] && wa[j] == a) r = {1'b1, wd[j]};
    end
    return r;
  endfunction

  task automatic model_update();
    if (m_pos != 0) begin
      m_reg[m_pos]  = '0;
      m_pend[m_pos] = 1'b0;
      m_pos = (m_pos == NREG - 1) ? 0 : m_pos + 1;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j] && wa[j] != 0) begin
          m_reg[wa[j]]  = wd[j];
          m_pend[wa[j]] = 1'b0;
        end
      end
      for (int a = 0; a < NA; a++) begin
        if (aen[a] && aa[a] != 0) m_pend[aa[a]] = 1'b1;
      end
      if (clr) m_pos = 1;
    end
  endtask

  task automatic clear_inputs();
    for (int j = 0; j < NW; j++) begin wen[j] = 0; wa[j] = 0; wd[j] = '0; end
    for (int a = 0; a < NA; a++) begin aen[a] = 0; aa[a] = 0; end
    clr = 0;
  endtask

  task automatic apply();
    for (int k = 0; k < NR; k++) bus.i_Read_Addr[k*AW +: AW] = rd_a[k][AW-1:0];
    for (int j = 0; j < NW; j++) begin
      bus.i_Write_Enable[j]       = wen[j];
      bus.i_Write_Addr[j*AW +: AW] = wa[j][AW-1:0];
      bus.i_Write_Data[j*DW +: DW] = wd[j];
    end
    for (int a = 0; a < NA; a++) begin
      bus.i_Alloc_Enable[a]        = aen[a];
      bus.i_Alloc_Addr[a*AW +: AW] = aa[a][AW-1:0];
    end
    bus.i_Clear_Req = clr;
  endtask

  task automatic check_outputs(input string tag);
    logic [32:0] e;
    for (int k = 0; k < NR; k++) begin
      e = mdl_read(rd_a[k]);
      chk($sformatf("%s_rd%0d_data", tag, k), bus.o_Read_Data[k*DW +: DW], e[31:0]);
      chk($sformatf("%s_rd%0d_rdy", tag, k), {31'h0, bus.o_Read_Ready[k]}, {31'h0, e[32]});
    end
    chk($sformatf("%s_busy", tag), {31'h0, bus.o_Clear_Busy}, {31'h0, m_pos != 0});
  endtask

  task automatic step(input string tag);
    apply();
    @(negedge clk);
    check_outputs(tag);
    last_busy = bus.o_Clear_Busy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rd_all(input int unsigned a);
    for (int k = 0; k < NR; k++) rd_a[k] = a;
  endtask

  task automatic rand_stim(input int unsigned amax);
    for (int k = 0; k < NR; k++) rd_a[k] = $urandom_range(0, amax);
    for (int j = 0; j < NW; j++) begin
      wen[j] = ($urandom_range(0, 2) != 0);
      wa[j]  = $urandom_range(0, amax);
      wd[j]  = $urandom;
    end
    for (int a = 0; a < NA; a++) begin
      aen[a] = ($urandom_range(0, 3) == 0);
      aa[a]  = $urandom_range(0, amax);
    end
  endtask

  task automatic fill_all();
    for (int b = 1; b < NREG; b += NW) begin
      clear_inputs();
      for (int j = 0; j < NW; j++) begin
        if (b + j < NREG) begin
          wen[j] = 1; wa[j] = b + j; wd[j] = $urandom | 32'h1;
        end
      end
      step("fill");
    end
    clear_inputs();
  endtask

  initial begin
    int cycles;
    rst_n = 1'b0;
    last_busy = 1'b0;
    clear_inputs();
    for (int k = 0; k < NR; k++) rd_a[k] = k * 3;
    model_reset();
    apply();
    #3;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single write, then read on every port
    clear_inputs(); rd_all(5);
    wen[0] = 1; wa[0] = 5; wd[0] = 32'hDEADBEEF;
    step("wr_r5");
    clear_inputs();
    step("rd_r5");
    chk("r5_const", bus.o_Read_Data[7*DW +: DW], 32'hDEADBEEF);

    // same-cycle collision: highest port wins, both in bypass and storage
    clear_inputs(); rd_all(9);
    wen[1] = 1; wa[1] = 9; wd[1] = 32'h11;
    wen[3] = 1; wa[3] = 9; wd[3] = 32'h33;
    apply(); @(negedge clk);
    chk("r9_bypass_const", bus.o_Read_Data[2*DW +: DW], 32'h33);
    @(posedge clk); model_update(); #1;
    clear_inputs();
    step("r9_stored");
    chk("r9_stored_const", bus.o_Read_Data[0 +: DW], 32'h33);

    // register 0 is hardwired
    clear_inputs(); rd_all(0);
    wen[2] = 1; wa[2] = 0; wd[2] = 32'hFFFF;
    step("wr_r0");
    clear_inputs();
    step("rd_r0");
    chk("r0_const", bus.o_Read_Data[4*DW +: DW], 32'h0);

    // scoreboard: alloc, writeback, alloc+write
    clear_inputs(); rd_all(12);
    aen[0] = 1; aa[0] = 12;
    step("alloc_r12");
    clear_inputs();
    step("pend_r12");
    chk("r12_pend_const", {31'h0, bus.o_Read_Ready[0]}, 32'h0);
    wen[0] = 1; wa[0] = 12; wd[0] = 32'h7;
    step("wb_r12");
    clear_inputs();
    step("wb_r12_after");
    chk("r12_clear_const", {31'h0, bus.o_Read_Ready[1]}, 32'h1);
    aen[2] = 1; aa[2] = 12; wen[1] = 1; wa[1] = 12; wd[1] = 32'h9;
    step("alloc_wr_r12");
    clear_inputs();
    step("alloc_wr_r12_after");
    chk("r12_alloc_wins_const", {31'h0, bus.o_Read_Ready[3]}, 32'h0);

    // full sweep: fill, pulse clear, everything dropped while busy
    fill_all();
    clr = 1;
    step("clr_pulse");
    clr = 0;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      clear_inputs();
      if (m_pos != 0) begin
        rand_stim(NREG - 1);
        clr = ($urandom_range(0, 7) == 0);
      end
      step("sweep");
      if (!last_busy) break;
      cycles++;
    end
    chk("sweep_len", cycles, 127);
    clear_inputs();
    for (int b = 0; b < NREG; b += NR) begin
      for (int k = 0; k < NR; k++) rd_a[k] = b + k;
      step("post_sweep");
      for (int k = 0; k < NR; k++) begin
        chk("post_sweep_data_const", bus.o_Read_Data[k*DW +: DW], 32'h0);
        chk("post_sweep_rdy_const", {31'h0, bus.o_Read_Ready[k]}, 32'h1);
      end
    end

    // async reset in the middle of a sweep
    fill_all();
    clr = 1;
    step("clr_pulse2");
    clr = 0;
    for (int i = 0; i < 200 && m_pos != 40; i++) begin
      rand_stim(NREG - 1);
      step("sweep2");
    end
    chk("reached_idx40", m_pos, 40);
    clear_inputs();
    for (int k = 0; k < NR; k++) rd_a[k] = 50 + k;
    apply();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("busy_async_rst", {31'h0, bus.o_Clear_Busy}, 32'h0);
    check_outputs("in_reset");
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < NREG; b += NR) begin
      for (int k = 0; k < NR; k++) rd_a[k] = b + k;
      step("after_rst");
    end
    rd_all(77);
    wen[0] = 1; wa[0] = 77; wd[0] = 32'hCAFE0077;
    step("new_wr");
    clear_inputs();
    step("new_wr_rd");
    chk("new_wr_const", bus.o_Read_Data[5*DW +: DW], 32'hCAFE0077);

    // random traffic over a small address pool to force collisions
    for (int i = 0; i < 800; i++) begin
      clear_inputs();
      rand_stim((i % 4 == 0) ? NREG - 1 : 15);
      clr = ($urandom_range(0, 149) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
